// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB-first, optional even parity, stop bit.
// Delivers each good word through a single holding register with a valid/ready handshake.
module serial_frame_rx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             par_q, par_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        par_d   = par_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (serial_in) begin
                    state_d = StData;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                end
            end
            StData: begin
                // Shift right so the first data bit ends up in bit 0.
                shift_d = {serial_in, shift_q[WIDTH-1:1]};
                par_d   = par_q ^ serial_in;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = PARITY_EN ? StParity : StStop;
                end
            end
            StParity: begin
                par_d   = par_q ^ serial_in;
                state_d = StStop;
            end
            StStop: begin
                state_d = StIdle;
                if (serial_in) begin
                    ferr_d = 1'b1;
                end else if (!valid_q || data_ready) begin
                    // A consume on this same edge frees the register for the new word.
                    data_d  = shift_q;
                    perr_d  = PARITY_EN ? par_q : 1'b0;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule
